// File: rtl/systolic_array_4x4.sv
// 4x4 output-stationary systolic MAC grid fed by skewed row/column streams; self-drains after the last feed.
// Define SA_SIGNED_EN for two's complement operands with signed accumulation (default: unsigned).
module systolic_array_4x4 #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ACC_WIDTH   = 2*DATA_WIDTH+2,
  parameter int unsigned FEED_STEPS  = 7,
  parameter int unsigned DRAIN_STEPS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   a_in0,
  input  logic [DATA_WIDTH-1:0]   a_in1,
  input  logic [DATA_WIDTH-1:0]   a_in2,
  input  logic [DATA_WIDTH-1:0]   a_in3,
  input  logic [DATA_WIDTH-1:0]   b_in0,
  input  logic [DATA_WIDTH-1:0]   b_in1,
  input  logic [DATA_WIDTH-1:0]   b_in2,
  input  logic [DATA_WIDTH-1:0]   b_in3,
  output logic                    busy,
  output logic                    result_valid,
  output logic [16*ACC_WIDTH-1:0] c_out,
  output logic                    err
);

  localparam int unsigned N      = 4;
  localparam int unsigned PROD_W = 2*DATA_WIDTH;
  localparam int unsigned EXT_W  = ACC_WIDTH - PROD_W;
  localparam int unsigned CNT_W  = $clog2(FEED_STEPS+1);

`ifdef SA_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ARMED, ACCUM, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic               err_d, busy_d, result_valid_d;
  logic               advance_c, clear_c, inject_zero_c;

  logic [DATA_WIDTH-1:0] a_in_arr [N];
  logic [DATA_WIDTH-1:0] b_in_arr [N];
  logic [DATA_WIDTH-1:0] a_reg  [N][N];
  logic [DATA_WIDTH-1:0] b_reg  [N][N];
  logic [DATA_WIDTH-1:0] a_left [N][N];
  logic [DATA_WIDTH-1:0] b_top  [N][N];
  logic [ACC_WIDTH-1:0]  acc    [N][N];
  logic [ACC_WIDTH-1:0]  term   [N][N];

  assign a_in_arr[0] = a_in0;
  assign a_in_arr[1] = a_in1;
  assign a_in_arr[2] = a_in2;
  assign a_in_arr[3] = a_in3;
  assign b_in_arr[0] = b_in0;
  assign b_in_arr[1] = b_in1;
  assign b_in_arr[2] = b_in2;
  assign b_in_arr[3] = b_in3;

  // Per-PE operand routing, product and extension to accumulator width
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic              sa, sb;
      logic [PROD_W-1:0] prod;

      if (gj == 0) begin : g_a_edge
        assign a_left[gi][gj] = inject_zero_c ? '0 : a_in_arr[gi];
      end else begin : g_a_inner
        assign a_left[gi][gj] = a_reg[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign b_top[gi][gj] = inject_zero_c ? '0 : b_in_arr[gj];
      end else begin : g_b_inner
        assign b_top[gi][gj] = b_reg[gi-1][gj];
      end

      // Low PROD_W bits of the extended product are exact in both signed and unsigned modes
      assign sa   = SIGNED_EN & a_left[gi][gj][DATA_WIDTH-1];
      assign sb   = SIGNED_EN & b_top[gi][gj][DATA_WIDTH-1];
      assign prod = {{DATA_WIDTH{sa}}, a_left[gi][gj]} * {{DATA_WIDTH{sb}}, b_top[gi][gj]};
      assign term[gi][gj] = {{EXT_W{SIGNED_EN & prod[PROD_W-1]}}, prod};

      assign c_out[(gi*N+gj)*ACC_WIDTH +: ACC_WIDTH] = acc[gi][gj];
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      step_q       <= '0;
      err          <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      err          <= err_d;
      busy         <= busy_d;
      result_valid <= result_valid_d;
    end
  end

  // Next-state, advance and clear decode
  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    err_d         = err;
    advance_c     = 1'b0;
    clear_c       = 1'b0;
    inject_zero_c = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = ARMED;
          step_d  = '0;
          err_d   = 1'b0;
          clear_c = 1'b1;
        end
      end
      ARMED, ACCUM: begin
        if (in_valid) begin
          advance_c = 1'b1;
          if (step_q == CNT_W'(FEED_STEPS-1)) begin
            state_d = DRAIN;
            step_d  = '0;
          end else begin
            state_d = ACCUM;
            step_d  = step_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        advance_c     = 1'b1;
        inject_zero_c = 1'b1;
        if (in_valid) err_d = 1'b1;
        if (step_q == CNT_W'(DRAIN_STEPS-1)) begin
          state_d = DONE;
          step_d  = '0;
        end else begin
          step_d = step_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d         = (state_d == ARMED) || (state_d == ACCUM) || (state_d == DRAIN);
    result_valid_d = (state_d == DONE);
  end

  // Systolic datapath: accumulate and shift on each advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc[i][j]   <= '0;
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
        end
      end
    end else if (clear_c) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc[i][j]   <= '0;
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
        end
      end
    end else if (advance_c) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc[i][j]   <= acc[i][j] + term[i][j];
          a_reg[i][j] <= a_left[i][j];
          b_reg[i][j] <= b_top[i][j];
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_4x4.sv
// Directed self-checking bench for systolic_array_4x4: skewed feeds, latency, protocol abuse, reset mid-op.
module tb_systolic_array_4x4;

  localparam int unsigned DW    = 32;
  localparam int unsigned ACC_W = 2*DW+2;
  localparam int unsigned CW    = 16*ACC_W;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid;
  logic [DW-1:0] a_drv [4];
  logic [DW-1:0] b_drv [4];
  logic          busy, result_valid, err;
  logic [CW-1:0] c_out;

  logic [DW-1:0]    mat_a [4][4];
  logic [DW-1:0]    mat_b [4][4];
  logic [ACC_W-1:0] exp_c [4][4];

  int n_cmp  = 0;
  int n_fail = 0;

  systolic_array_4x4 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .a_in0        (a_drv[0]),
    .a_in1        (a_drv[1]),
    .a_in2        (a_drv[2]),
    .a_in3        (a_drv[3]),
    .b_in0        (b_drv[0]),
    .b_in1        (b_drv[1]),
    .b_in2        (b_drv[2]),
    .b_in3        (b_drv[3]),
    .busy         (busy),
    .result_valid (result_valid),
    .c_out        (c_out),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_bus_zero(input string tag);
    n_cmp++;
    assert (c_out === '0) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=0", tag, c_out);
    end
  endtask

  function automatic logic [ACC_W-1:0] cval(input int i, input int j);
    return c_out[(i*4+j)*ACC_W +: ACC_W];
  endfunction

  task automatic check_mat(input string tag);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("%s_c%0d%0d", tag, i, j), cval(i, j), exp_c[i][j]);
  endtask

  task automatic zero_inputs();
    for (int i = 0; i < 4; i++) begin
      a_drv[i] = '0;
      b_drv[i] = '0;
    end
  endtask

  // Upstream skew: row I lags by I steps, column J lags by J steps, zero outside the window
  task automatic drive_step(input int t);
    for (int i = 0; i < 4; i++) begin
      a_drv[i] = (t-i >= 0 && t-i < 4) ? mat_a[i][t-i] : '0;
      b_drv[i] = (t-i >= 0 && t-i < 4) ? mat_b[t-i][i] : '0;
    end
  endtask

  task automatic feed(input int first, input int last, input int spacing);
    for (int t = first; t <= last; t++) begin
      drive_step(t);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      zero_inputs();
      if (t < last) repeat (spacing-1) tick();
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called right after the edge accepting the final strobe
  task automatic finish_check(input string tag, input bit drain_abuse);
    chk({tag, "_busy_T"}, ACC_W'(busy), ACC_W'(1));
    chk({tag, "_rv_T"}, ACC_W'(result_valid), '0);
    if (drain_abuse) begin
      for (int i = 0; i < 4; i++) begin
        a_drv[i] = 32'd99;
        b_drv[i] = 32'd99;
      end
      in_valid = 1'b1;
    end
    tick();
    in_valid = 1'b0;
    zero_inputs();
    if (drain_abuse) chk({tag, "_err_drain"}, ACC_W'(err), ACC_W'(1));
    chk({tag, "_rv_T1"}, ACC_W'(result_valid), '0);
    tick();
    chk({tag, "_rv_T2"}, ACC_W'(result_valid), '0);
    tick();
    chk({tag, "_rv_T3"}, ACC_W'(result_valid), ACC_W'(1));
    chk({tag, "_busy_T3"}, ACC_W'(busy), '0);
  endtask

  task automatic set_a_seq();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        mat_a[i][j] = DW'(i*4 + j + 1);
  endtask

  task automatic set_b_diag(input int d);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        mat_b[i][j] = (i == j) ? DW'(d) : '0;
  endtask

  task automatic set_exp_scaled_a(input int s);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        exp_c[i][j] = ACC_W'((i*4 + j + 1) * s);
  endtask

  task automatic model_product();
    logic [ACC_W-1:0] s;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = '0;
        for (int k = 0; k < 4; k++)
          s = s + ACC_W'(mat_a[i][k]) * ACC_W'(mat_b[k][j]);
        exp_c[i][j] = s;
      end
  endtask

  initial begin
    logic [ACC_W-1:0] sgn_exp;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    zero_inputs();
    set_a_seq();
    set_b_diag(1);
    repeat (2) tick();

    chk("rst_busy", ACC_W'(busy), '0);
    chk("rst_rv", ACC_W'(result_valid), '0);
    chk("rst_err", ACC_W'(err), '0);
    chk_bus_zero("rst_c_out");
    rst_n = 1'b1;
    tick();

    // Strobe in IDLE must be ignored
    drive_step(0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    zero_inputs();
    chk("idle_strobe_busy", ACC_W'(busy), '0);
    chk("idle_strobe_rv", ACC_W'(result_valid), '0);
    chk("idle_strobe_c00", cval(0, 0), '0);

    // Identity, strobes spaced 10 cycles
    do_start();
    chk("id_busy_armed", ACC_W'(busy), ACC_W'(1));
    chk("id_rv_armed", ACC_W'(result_valid), '0);
    feed(0, 6, 10);
    finish_check("id", 1'b0);
    set_exp_scaled_a(1);
    check_mat("id");

    // Square: B = A
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        mat_b[i][j] = mat_a[i][j];
    do_start();
    chk("sq_rv_drop", ACC_W'(result_valid), '0);
    feed(0, 6, 1);
    finish_check("sq", 1'b0);
    chk("sq_c00_hand", cval(0, 0), ACC_W'(90));
    chk("sq_c33_hand", cval(3, 3), ACC_W'(600));
    model_product();
    check_mat("sq");

    // Signed operands: A all -1, B all 2
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mat_a[i][j] = 32'hFFFF_FFFF;
        mat_b[i][j] = 32'd2;
      end
`ifdef SA_SIGNED_EN
    sgn_exp = '0 - ACC_W'(8);
`else
    sgn_exp = ACC_W'(36'h7_FFFF_FFF8);
`endif
    do_start();
    feed(0, 6, 2);
    finish_check("sgn", 1'b0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        exp_c[i][j] = sgn_exp;
    check_mat("sgn");

    // Strobe in DONE ignored, results held
    set_a_seq();
    set_b_diag(2);
    drive_step(0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    zero_inputs();
    chk("done_strobe_rv", ACC_W'(result_valid), ACC_W'(1));
    chk("done_strobe_busy", ACC_W'(busy), '0);
    chk("done_strobe_c00", cval(0, 0), sgn_exp);

    // Start and strobe together from DONE: start wins, strobe dropped
    drive_step(0);
    start    = 1'b1;
    in_valid = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    zero_inputs();
    chk("b2b_busy", ACC_W'(busy), ACC_W'(1));
    chk("b2b_rv_low", ACC_W'(result_valid), '0);
    chk("b2b_c00_cleared", cval(0, 0), '0);
    feed(0, 3, 3);

    // Start during ACCUM ignored: PE(0,0) already holds A00*2
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("accum_start_busy", ACC_W'(busy), ACC_W'(1));
    chk("accum_start_c00", cval(0, 0), ACC_W'(2));
    feed(4, 6, 3);
    finish_check("b2b", 1'b1);
    chk("b2b_err_sticky", ACC_W'(err), ACC_W'(1));
    set_exp_scaled_a(2);
    check_mat("b2b");

    // Reset in the middle of ACCUM
    set_b_diag(1);
    do_start();
    chk("rstmid_err_cleared", ACC_W'(err), '0);
    feed(0, 3, 2);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", ACC_W'(busy), '0);
    chk("rstmid_rv", ACC_W'(result_valid), '0);
    chk("rstmid_err", ACC_W'(err), '0);
    chk_bus_zero("rstmid_c_out");
    tick();
    rst_n = 1'b1;
    tick();
    do_start();
    feed(0, 6, 4);
    finish_check("post", 1'b0);
    set_exp_scaled_a(1);
    check_mat("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
